instr_mem_sync: RTL and testbench



---
 rtl/instr_mem_sync.sv | 206 ++++++++++++++++++++
 tb/tb_instr_mem_sync.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// -----------------------------------------------------------------------------
// instr_mem_sync
//
// Synchronous-read instruction memory for the IF stage of the pipelined CPU.
// Byte-addressed and little-endian at the interface. Internally the array holds
// one full instruction word per entry, because both ports only touch aligned
// words: misaligned fetches return a NOP and misaligned loads are rejected.
//
// After reset a boot sequencer writes zero to one word per cycle. When every
// word has been cleared it raises ready. From then on, fetches and loader
// writes are accepted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cs_rom     fetch enable; 0 returns i_out=0 with i_valid/misalign/oob = 0
//   stall      hold all fetch outputs (takes priority over cs_rom)
//   pc_addr    fetch byte address
//   i_out      fetched word {byte[a+WB-1],...,byte[a]}, one cycle after pc_addr
//   i_valid    i_out holds a fetch result
//   misalign   last fetch address was not word aligned
//   oob        last fetch address was beyond the last full word
//   ready      boot clear finished
//   ld_we      loader write request
//   ld_addr    loader byte address (must be word aligned and in range)
//   ld_wdata   loader word, byte 0 lands at ld_addr
//   ld_ack     one-cycle pulse, write committed
//   ld_err     one-cycle pulse, write rejected
// -----------------------------------------------------------------------------
module instr_mem_sync #(
  parameter int BYTE        = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int ROM_DEPTH   = 256,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs_rom,
  input  logic                   stall,
  input  logic [ADDR_WIDTH-1:0]  pc_addr,
  output logic [INSTR_WIDTH-1:0] i_out,
  output logic                   i_valid,
  output logic                   misalign,
  output logic                   oob,
  output logic                   ready,
  input  logic                   ld_we,
  input  logic [ADDR_WIDTH-1:0]  ld_addr,
  input  logic [INSTR_WIDTH-1:0] ld_wdata,
  output logic                   ld_ack,
  output logic                   ld_err
);

  localparam int WB     = INSTR_WIDTH / BYTE;
  localparam int NWORDS = ROM_DEPTH / WB;
  localparam int SHIFT  = (WB > 1) ? $clog2(WB) : 0;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  // Highest legal word-start byte address. Compared at full ADDR_WIDTH so that
  // high address bits can never alias back into the array.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_DEPTH - WB);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(WB - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NWORDS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Address decode, one identical decoder per port (0 = fetch, 1 = loader)
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] dec_addr     [2];
  logic [IDX_W-1:0]      dec_idx      [2];
  logic [1:0]            dec_misal;
  logic [1:0]            dec_in_range;

  assign dec_addr[0] = pc_addr;
  assign dec_addr[1] = ld_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dec
      assign dec_misal[gi]    = (dec_addr[gi] & OFF_MASK) != '0;
      assign dec_in_range[gi] = dec_addr[gi] <= LAST_ADDR;
      assign dec_idx[gi]      = IDX_W'(dec_addr[gi] >> SHIFT);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  logic [IDX_W-1:0] clr_cnt_reg;
  logic             ready_reg;
  logic             valid_reg;
  logic             misalign_reg;
  logic             oob_reg;
  logic             show_reg;   // i_out shows the RAM read data, else NOP
  logic             ld_ack_reg;
  logic             ld_err_reg;

  logic                   clearing;
  logic                   ld_commit;
  logic                   fetch_accept;
  logic                   fetch_rd;
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_waddr;
  logic [INSTR_WIDTH-1:0] mem_wdata;
  logic [IDX_W-1:0]       rd_idx;

  always_comb begin
    clearing     = (state_reg == ST_CLEAR);
    ld_commit    = (state_reg == ST_RUN) && ld_we && !dec_misal[1] && dec_in_range[1];
    fetch_accept = ready_reg && !stall;
    // A real RAM read only happens for an enabled, aligned, in-range fetch.
    fetch_rd     = fetch_accept && cs_rom && !dec_misal[0] && dec_in_range[0];
    rd_idx       = dec_in_range[0] ? dec_idx[0] : '0;

    // The boot clear and the loader share the single write port. They never
    // collide, because the loader is only honoured in RUN.
    mem_we    = clearing || ld_commit;
    mem_waddr = clearing ? clr_cnt_reg : dec_idx[1];
    mem_wdata = clearing ? '0 : ld_wdata;
  end

  // ---------------------------------------------------------------------------
  // Storage: one write port, one registered read port. There is no reset here,
  // so the array can map onto block RAM. Nonblocking semantics give read-first
  // behaviour when a fetch and a load hit the same word in the same cycle.
  // ---------------------------------------------------------------------------
  logic [INSTR_WIDTH-1:0] mem [NWORDS];
  logic [INSTR_WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (fetch_rd) begin
      rd_data_reg <= mem[rd_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM plus registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_CLEAR;
      clr_cnt_reg  <= '0;
      ready_reg    <= 1'b0;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      oob_reg      <= 1'b0;
      show_reg     <= 1'b0;
      ld_ack_reg   <= 1'b0;
      ld_err_reg   <= 1'b0;
    end else begin
      ld_ack_reg <= 1'b0;
      ld_err_reg <= 1'b0;

      case (state_reg)
        ST_CLEAR: begin
          if (clr_cnt_reg == LAST_IDX) begin
            state_reg <= ST_RUN;
            ready_reg <= 1'b1;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          // Stays here until the next reset.
        end
        default: begin
          state_reg <= ST_CLEAR;
        end
      endcase

      if (ld_we) begin
        if (ld_commit) begin
          ld_ack_reg <= 1'b1;
        end else begin
          ld_err_reg <= 1'b1;
        end
      end

      // When stall is high, every fetch output keeps its value.
      if (fetch_accept) begin
        valid_reg    <= cs_rom;
        misalign_reg <= cs_rom && dec_misal[0];
        oob_reg      <= cs_rom && !dec_in_range[0];
        show_reg     <= fetch_rd;
      end
    end
  end

  // The RAM output register cannot take the asynchronous reset. Gating it with
  // show_reg gives a zero on i_out for NOP, disabled and reset cases.
  assign i_out    = show_reg ? rd_data_reg : '0;
  assign i_valid  = valid_reg;
  assign misalign = misalign_reg;
  assign oob      = oob_reg;
  assign ready    = ready_reg;
  assign ld_ack   = ld_ack_reg;
  assign ld_err   = ld_err_reg;

endmodule

// File: tb/tb_instr_mem_sync.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_sync
//
// Directed testbench for instr_mem_sync at its default parameters
// (32-bit words, 256 bytes, 64 words). Inputs change on the falling edge.
// Outputs are sampled on the next falling edge, after the rising edge that
// acted on those inputs.
// -----------------------------------------------------------------------------
module tb_instr_mem_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_rom;
  logic        stall;
  logic [31:0] pc_addr;
  logic [31:0] i_out;
  logic        i_valid;
  logic        misalign;
  logic        oob;
  logic        ready;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ack;
  logic        ld_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_mem_sync #(
    .BYTE        (8),
    .INSTR_WIDTH (32),
    .ROM_DEPTH   (256),
    .ADDR_WIDTH  (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_rom   (cs_rom),
    .stall    (stall),
    .pc_addr  (pc_addr),
    .i_out    (i_out),
    .i_valid  (i_valid),
    .misalign (misalign),
    .oob      (oob),
    .ready    (ready),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .ld_ack   (ld_ack),
    .ld_err   (ld_err)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    checks++;
    if (i_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_i_out: got %h expected 00000000", i_out);
    end
    checks++;
    if ({i_valid, misalign, oob, ready, ld_ack, ld_err} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_status: got %b expected 000000",
               {i_valid, misalign, oob, ready, ld_ack, ld_err});
    end
    $display("reset: i_out=%h status=%b", i_out, {i_valid, misalign, oob, ready, ld_ack, ld_err});
  endtask

  // Releases reset, then counts the cycles until ready rises. Fetches are
  // requested the whole time, so the clear phase must keep i_valid and i_out low.
  task automatic test_boot(input string tag);
    int cycles;
    bit clr_bad;
    cycles  = 0;
    clr_bad = 1'b0;
    cs_rom  = 1'b1;
    pc_addr = 32'h0;
    rst_n   = 1'b1;
    while (ready !== 1'b1 && cycles < 200) begin
      step();
      cycles++;
      if (ready !== 1'b1 && (i_valid !== 1'b0 || i_out !== 32'h0)) clr_bad = 1'b1;
    end
    checks++;
    if (cycles !== 64) begin
      errors++;
      $display("FAIL %s_clear_cycles: got %0d expected 64", tag, cycles);
    end
    checks++;
    if (clr_bad !== 1'b0) begin
      errors++;
      $display("FAIL %s_fetch_during_clear: got output activity expected none", tag);
    end
    $display("%s: ready after %0d cycles", tag, cycles);
  endtask

  task automatic test_zero_fetch();
    cs_rom  = 1'b1;
    pc_addr = 32'h10;
    step();
    checks++;
    if ({i_valid, misalign, oob, i_out} !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL zero_fetch: got v/m/o=%b%b%b i_out=%h expected 100 00000000",
               i_valid, misalign, oob, i_out);
    end
    $display("fetch pc=%h i_out=%h v=%b", pc_addr, i_out, i_valid);
  endtask

  task automatic test_load();
    cs_rom   = 1'b0;
    ld_we    = 1'b1;
    ld_addr  = 32'h0;
    ld_wdata = 32'h2001_0008;
    step();
    checks++;
    if ({ld_ack, ld_err} !== 2'b10) begin
      errors++;
      $display("FAIL load0_ack: got ack/err=%b%b expected 10", ld_ack, ld_err);
    end
    checks++;
    if ({i_valid, i_out} !== 33'h0) begin
      errors++;
      $display("FAIL cs_off_output: got v=%b i_out=%h expected 0 00000000", i_valid, i_out);
    end
    $display("load addr=00 data=20010008 ack=%b err=%b", ld_ack, ld_err);
    ld_addr  = 32'h4;
    ld_wdata = 32'h3402_000C;
    step();
    checks++;
    if ({ld_ack, ld_err} !== 2'b10) begin
      errors++;
      $display("FAIL load4_ack: got ack/err=%b%b expected 10", ld_ack, ld_err);
    end
    $display("load addr=04 data=3402000C ack=%b err=%b", ld_ack, ld_err);
    ld_we = 1'b0;
    step();
    checks++;
    if ({ld_ack, ld_err} !== 2'b00) begin
      errors++;
      $display("FAIL ack_one_cycle: got ack/err=%b%b expected 00", ld_ack, ld_err);
    end
  endtask

  task automatic test_back_to_back();
    cs_rom  = 1'b1;
    pc_addr = 32'h0;
    step();
    checks++;
    if ({i_valid, i_out} !== {1'b1, 32'h2001_0008}) begin
      errors++;
      $display("FAIL b2b_fetch0: got v=%b i_out=%h expected 1 20010008", i_valid, i_out);
    end
    $display("fetch pc=00 i_out=%h", i_out);
    pc_addr = 32'h4;
    step();
    checks++;
    if ({i_valid, i_out} !== {1'b1, 32'h3402_000C}) begin
      errors++;
      $display("FAIL b2b_fetch4: got v=%b i_out=%h expected 1 3402000C", i_valid, i_out);
    end
    $display("fetch pc=04 i_out=%h", i_out);
  endtask

  task automatic test_misalign_oob();
    logic [31:0] pcs   [5] = '{32'h2, 32'h100, 32'hFE, 32'hFC, 32'h8000_0004};
    logic [1:0]  flags [5] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b01};
    cs_rom = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc_addr = pcs[i];
      step();
      checks++;
      if ({i_valid, misalign, oob, i_out} !== {1'b1, flags[i], 32'h0}) begin
        errors++;
        $display("FAIL flags_pc_%h: got v/m/o=%b%b%b i_out=%h expected 1%b 00000000",
                 pcs[i], i_valid, misalign, oob, i_out, flags[i]);
      end
      $display("fetch pc=%h i_out=%h mis=%b oob=%b", pcs[i], i_out, misalign, oob);
    end
  endtask

  task automatic test_stall();
    cs_rom  = 1'b1;
    pc_addr = 32'h4;
    step();
    checks++;
    if (i_out !== 32'h3402_000C) begin
      errors++;
      $display("FAIL stall_pre: got %h expected 3402000C", i_out);
    end
    stall   = 1'b1;
    pc_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      cs_rom = (i != 1);   // stall must also win over cs_rom=0
      step();
      checks++;
      if ({i_valid, misalign, oob, i_out} !== {3'b100, 32'h3402_000C}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v/m/o=%b%b%b i_out=%h expected 100 3402000C",
                 i, i_valid, misalign, oob, i_out);
      end
      $display("stall cycle %0d i_out=%h", i, i_out);
    end
    stall  = 1'b0;
    cs_rom = 1'b1;
    step();
    checks++;
    if (i_out !== 32'h2001_0008) begin
      errors++;
      $display("FAIL stall_release: got %h expected 20010008", i_out);
    end
    $display("stall released, fetch pc=00 i_out=%h", i_out);
  endtask

  task automatic test_read_first();
    cs_rom   = 1'b1;
    pc_addr  = 32'h4;
    ld_we    = 1'b1;
    ld_addr  = 32'h4;
    ld_wdata = 32'hAAAA_AAAA;
    step();
    checks++;
    if ({ld_ack, i_out} !== {1'b1, 32'h3402_000C}) begin
      errors++;
      $display("FAIL read_first_old: got ack=%b i_out=%h expected 1 3402000C", ld_ack, i_out);
    end
    $display("write+fetch 04 i_out=%h ack=%b", i_out, ld_ack);
    ld_we = 1'b0;
    step();
    checks++;
    if (i_out !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL read_first_new: got %h expected AAAAAAAA", i_out);
    end
    $display("fetch 04 i_out=%h", i_out);
  endtask

  task automatic test_ld_reject();
    logic [31:0] bad [3] = '{32'h2, 32'h100, 32'h8000_0000};
    cs_rom   = 1'b0;
    ld_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      ld_we   = 1'b1;
      ld_addr = bad[i];
      step();
      checks++;
      if ({ld_ack, ld_err} !== 2'b01) begin
        errors++;
        $display("FAIL ld_reject_%h: got ack/err=%b%b expected 01", bad[i], ld_ack, ld_err);
      end
      $display("load addr=%h ack=%b err=%b", bad[i], ld_ack, ld_err);
    end
    ld_we   = 1'b0;
    cs_rom  = 1'b1;
    pc_addr = 32'h0;
    step();
    checks++;
    if (i_out !== 32'h2001_0008) begin
      errors++;
      $display("FAIL ld_reject_intact: got %h expected 20010008", i_out);
    end
  endtask

  task automatic test_reset_mid_clear();
    // Asynchronous reset from RUN clears the outputs before any clock edge.
    rst_n = 1'b0;
    #1;
    checks++;
    if ({i_out, i_valid, ready} !== 34'h0) begin
      errors++;
      $display("FAIL async_reset: got i_out=%h v=%b ready=%b expected 0", i_out, i_valid, ready);
    end
    step();
    rst_n    = 1'b1;
    cs_rom   = 1'b0;
    ld_addr  = 32'h8;
    ld_wdata = 32'h1234_5678;
    for (int c = 0; c < 10; c++) begin
      ld_we = (c == 2);
      step();
      if (c == 2) begin
        checks++;
        if ({ld_ack, ld_err} !== 2'b01) begin
          errors++;
          $display("FAIL ld_in_clear: got ack/err=%b%b expected 01", ld_ack, ld_err);
        end
        $display("load during clear ack=%b err=%b", ld_ack, ld_err);
      end
    end
    ld_we = 1'b0;
    rst_n = 1'b0;
    #1;
    step();
    test_boot("reboot");
    cs_rom  = 1'b1;
    pc_addr = 32'h8;
    step();
    checks++;
    if ({i_valid, i_out} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reboot_fetch8: got v=%b i_out=%h expected 1 00000000", i_valid, i_out);
    end
    pc_addr = 32'h0;
    step();
    checks++;
    if ({i_valid, i_out} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reboot_fetch0: got v=%b i_out=%h expected 1 00000000", i_valid, i_out);
    end
    $display("after reboot fetch pc=00 i_out=%h", i_out);
  endtask

  initial begin
    rst_n    = 1'b0;
    cs_rom   = 1'b0;
    stall    = 1'b0;
    pc_addr  = 32'h0;
    ld_we    = 1'b0;
    ld_addr  = 32'h0;
    ld_wdata = 32'h0;
    test_reset();
    test_boot("boot");
    test_zero_fetch();
    test_load();
    test_back_to_back();
    test_misalign_oob();
    test_stall();
    test_read_first();
    test_ld_reject();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
